// File: rtl/student_pkg.sv
// Shared definitions for the student operand datapath: state encoding of the
// operand skid buffer and the common word width.
package student_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/student_operand_skid16.sv
// Two-entry skid buffer for {a, b} operand pairs feeding the 16-bit bitwise stage.
// All outputs are registered so neither ready nor valid has a combinational path.
module student_operand_skid16
  import student_pkg::*;
#(
  parameter int WIDTH     = WORD_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic [1:0]           occupancy,
  output logic [CNT_WIDTH-1:0] xfer_count
);

  // Handshake: a pair moves on an edge where valid and ready are both high;
  // a producer holds valid and data steady until that edge.

  skid_state_t          state, state_d;
  logic [2*WIDTH-1:0]   main_q, skid_q;
  logic [2*WIDTH-1:0]   in_pair;
  logic                 in_fire, out_fire;
  logic                 load_main_in, load_main_skid, load_skid;

  assign in_pair  = {in_a, in_b};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_a    = main_q[2*WIDTH-1:WIDTH];
  assign out_b    = main_q[WIDTH-1:0];

  always_comb begin
    state_d        = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_d      = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (out_fire) begin
          // main keeps its stale contents; out_valid drops so it is never seen.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d        = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      occupancy  <= 2'd0;
      xfer_count <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= (state_d != FULL);
      out_valid <= (state_d != EMPTY);
      occupancy <= occ_of(state_d);
      if (load_main_in) begin
        main_q <= in_pair;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_pair;
      end
      if (out_fire) begin
        xfer_count <= xfer_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_student_operand_skid16.sv
// Bench for student_operand_skid16: directed steps plus random traffic checked
// against a queue model of the buffer; a 4-bit-counter instance covers the wrap.
module tb_student_operand_skid16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic        in_ready, out_valid;
  logic [15:0] out_a, out_b;
  logic [1:0]  occupancy;
  logic [15:0] xfer_count;
  logic        in_ready4, out_valid4;
  logic [15:0] out_a4, out_b4;
  logic [1:0]  occupancy4;
  logic [3:0]  xfer_count4;

  int errors = 0;
  int checks = 0;

  // Reference model: queue of held pairs, last delivered pair, delivered count.
  logic [31:0] exp_q[$];
  logic [31:0] last_pair;
  int unsigned exp_cnt;

  always #5 clk = ~clk;

  student_operand_skid16 #(.WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .occupancy(occupancy), .xfer_count(xfer_count)
  );

  student_operand_skid16 #(.WIDTH(16), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready4), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid4), .out_ready(out_ready), .out_a(out_a4), .out_b(out_b4),
    .occupancy(occupancy4), .xfer_count(xfer_count4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [31:0] head;
    int unsigned n;
    n    = exp_q.size();
    head = (n > 0) ? exp_q[0] : last_pair;
    chk("in_ready",   32'(in_ready),   32'(n < 2));
    chk("out_valid",  32'(out_valid),  32'(n > 0));
    chk("occupancy",  32'(occupancy),  n);
    chk("out_a",      32'(out_a),      32'(head[31:16]));
    chk("out_b",      32'(out_b),      32'(head[15:0]));
    chk("xfer_count", 32'(xfer_count), 32'(exp_cnt[15:0]));
    chk("xfer4",      32'(xfer_count4), 32'(exp_cnt[3:0]));
    chk("occ4",       32'(occupancy4), n);
  endtask

  // One clock: drive inputs, check the registered outputs, advance the model.
  task automatic cycle(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic ordy, output logic accepted);
    logic m_in, m_out;
    in_valid  = iv;
    in_a      = ia;
    in_b      = ib;
    out_ready = ordy;
    #1;
    check_outputs();
    m_in  = iv && (exp_q.size() < 2);
    m_out = ordy && (exp_q.size() > 0);
    @(posedge clk);
    #1;
    if (m_out) begin
      last_pair = exp_q.pop_front();
      exp_cnt++;
    end
    if (m_in) exp_q.push_back({ia, ib});
    accepted = m_in;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_a      = 16'hDEAD;
    in_b      = 16'hBEEF;
    @(posedge clk);
    #1;
    exp_q.delete();
    last_pair = '0;
    exp_cnt   = 0;
    reset_n   = 1'b1;
  endtask

  logic acc;
  int   budget;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    last_pair = '0; exp_cnt = 0;
    @(posedge clk);
    #1;
    do_reset();

    // Idle after reset
    repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b0, acc);

    // Pass-through with out_ready held high
    cycle(1'b1, 16'hAAAA, 16'h5555, 1'b1, acc);
    cycle(1'b1, 16'h3CC3, 16'h0FF0, 1'b1, acc);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);
    chk("pass_count", 32'(xfer_count), 32'd2);

    // Backpressure: fill, hold off the third pair, then drain in order
    cycle(1'b1, 16'h0000, 16'hFFFF, 1'b0, acc);
    cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, acc);
    cycle(1'b1, 16'h1234, 16'h9876, 1'b0, acc);
    chk("bp_held_off", 32'(acc), 32'd0);
    chk("bp_out_a_stable", 32'(out_a), 32'h0000);
    budget = 0;
    acc = 1'b0;
    while (!acc && budget < 10) begin
      cycle(1'b1, 16'h1234, 16'h9876, 1'b1, acc);
      budget++;
    end
    chk("bp_accept_in_budget", 32'(acc), 32'd1);
    repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);

    // Simultaneous in/out fire while ONE
    cycle(1'b1, 16'h1111, 16'h2222, 1'b0, acc);
    cycle(1'b1, 16'h4444, 16'h8888, 1'b1, acc);
    chk("sim_occ", 32'(occupancy), 32'd1);
    chk("sim_out_a", 32'(out_a), 32'h4444);
    cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);

    // Reset while FULL discards both held pairs
    cycle(1'b1, 16'hCAFE, 16'h0001, 1'b0, acc);
    cycle(1'b1, 16'hF00D, 16'h0002, 1'b0, acc);
    chk("full_occ", 32'(occupancy), 32'd2);
    do_reset();
    repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, 16'(i), 16'(~i), 1'b1, acc);
      if (exp_cnt == 15) chk("wrap_15", 32'(xfer_count4), 32'hF);
      if (exp_cnt == 16) chk("wrap_16", 32'(xfer_count4), 32'h0);
      if (exp_cnt == 17) chk("wrap_17", 32'(xfer_count4), 32'h1);
    end
    repeat (2) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);

    // Random traffic, with an occasional reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 99) < 55), acc);
    end
    repeat (3) cycle(1'b0, 16'h0, 16'h0, 1'b1, acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
